clkdiv_multi: RTL

Parametrised N-channel clock-enable generator. It is the successor to the fixed 25 MHz / 10 ms / scan-rate divider. Each channel has its own runtime-programmable divisor and produces two outputs from the single clk_100mhz domain: a one-cycle tick strobe and a near-50% square wave. It feeds the VGA/PS2, game-tick and seven-segment scan logic, which use tick as a clock enable and never as a clock.

---
 rtl/clkdiv_pkg.sv | 16 +
 rtl/clkdiv_chan.sv | 89 ++++++++
 rtl/clkdiv_multi.sv | 54 +++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-enable divider: default width, named divisors, divisor clamp.
// Optional CLKDIV_TICKCNT_EN build adds per-channel tick counters (see clkdiv_chan / clkdiv_multi).
package clkdiv_pkg;

   localparam int CNT_W_DEF     = 24;

   localparam int DIV_VGA_25MHZ = 4;
   localparam int DIV_GAME_10MS = 1000000;
   localparam int DIV_SEG_SCAN  = 131072;

   // A divisor of 0 would never reach terminal count, so it runs as 1.
   function automatic logic [31:0] clamp_div(input logic [31:0] div);
      return (div == 32'd0) ? 32'd1 : div;
   endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, shadow divisor, registered tick/sq strobes.
// With CLKDIV_TICKCNT_EN defined it also keeps a 16-bit saturating tick counter.
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DIV_INIT = DIV_GAME_10MS
) (
   input  logic             clk_100mhz,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
`ifdef CLKDIV_TICKCNT_EN
   input  logic             cnt_clr,
   output logic [15:0]      tick_cnt,
`endif
   output logic             pending,
   output logic             tick,
   output logic             sq,
   output logic [CNT_W-1:0] div_act
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(clamp_div(32'(DIV_INIT)));

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] wr_val;
   logic [CNT_W-1:0] div_next;
   logic [CNT_W-1:0] cnt_next;
   logic             terminal;
   logic             sq_next;

   always_comb begin
      // NOTE: every signal is assigned on all paths of an always_comb, otherwise a latch is inferred.
      wr_val   = CNT_W'(clamp_div(32'(wr_div)));
      terminal = (cnt == div_act - CNT_W'(1));
      div_next = (terminal && pending) ? shadow : div_act;
      cnt_next = terminal ? '0 : cnt + CNT_W'(1);
      sq_next  = (cnt_next >= (div_next >> 1));
   end

   always_ff @(posedge clk_100mhz) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         cnt     <= '0;
         div_act <= DIV_RST;
         shadow  <= DIV_RST;
         pending <= 1'b0;
         tick    <= 1'b0;
         sq      <= 1'b0;
      end else if (sync || !en) begin
         // Restart point: a write on this same edge takes effect immediately.
         cnt     <= '0;
         tick    <= 1'b0;
         sq      <= 1'b0;
         pending <= 1'b0;
         if (wr) begin
            div_act <= wr_val;
            shadow  <= wr_val;
         end else if (pending) begin
            div_act <= shadow;
         end
      end else begin
         cnt  <= cnt_next;
         tick <= terminal;
         sq   <= sq_next;
         if (wr) shadow <= wr_val;
         if (terminal) begin
            div_act <= div_next;
            pending <= wr;
         end else if (wr) begin
            pending <= 1'b1;
         end
      end
   end

`ifdef CLKDIV_TICKCNT_EN
   always_ff @(posedge clk_100mhz) begin
      if (!rst || cnt_clr) begin
         tick_cnt <= '0;
      end else if (tick && (tick_cnt != 16'hFFFF)) begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// N-channel clock-enable generator: decodes divisor writes and fans sync out to clkdiv_chan.
// Define CLKDIV_TICKCNT_EN to add cnt_clr / tick_cnt (per-channel saturating tick counts).
module clkdiv_multi
   import clkdiv_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DIV_INIT = DIV_GAME_10MS,
   parameter int CH_W     = 2
) (
   input  logic                  clk_100mhz,
   input  logic                  rst,
   input  logic [N_CH-1:0]       en,
   input  logic                  sync,
   input  logic                  cfg_we,
   input  logic [CH_W-1:0]       cfg_ch,
   input  logic [CNT_W-1:0]      cfg_div,
`ifdef CLKDIV_TICKCNT_EN
   input  logic                  cnt_clr,
   output logic [N_CH*16-1:0]    tick_cnt,
`endif
   output logic [N_CH-1:0]       cfg_pending,
   output logic [N_CH-1:0]       tick,
   output logic [N_CH-1:0]       sq,
   output logic [N_CH*CNT_W-1:0] div_act
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      // Channel numbers at or above N_CH match no instance, so those writes drop.
      logic wr;
      assign wr = cfg_we && (cfg_ch == CH_W'(i));

      clkdiv_chan #(
         .CNT_W    (CNT_W),
         .DIV_INIT (DIV_INIT)
      ) u_chan (
         .clk_100mhz (clk_100mhz),
         .rst        (rst),
         .en         (en[i]),
         .sync       (sync),
         .wr         (wr),
         .wr_div     (cfg_div),
`ifdef CLKDIV_TICKCNT_EN
         .cnt_clr    (cnt_clr),
         .tick_cnt   (tick_cnt[i*16 +: 16]),
`endif
         .pending    (cfg_pending[i]),
         .tick       (tick[i]),
         .sq         (sq[i]),
         .div_act    (div_act[i*CNT_W +: CNT_W])
      );
   end

endmodule
